// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, reads instruction memory combinationally,
// and loads the IF/ID register; stops fetching on HLT until a flush or reset.
module fetch_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [15:0] branch_target,
  input  logic [15:0] imem_data,
  output logic [15:0] imem_addr,
  output logic [15:0] instr_out,
  output logic [15:0] pc_next_out,
  output logic        valid_out,
  output logic        halted
);

  typedef enum logic {
    S_RUN    = 1'b0,
    S_HALTED = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [15:0] r_pc;
  logic [15:0] w_pc_next;
  logic [15:0] r_instr;
  logic [15:0] w_instr_next;
  logic [15:0] r_ifid_pc2;
  logic [15:0] w_ifid_pc2_next;
  logic        r_valid;
  logic        w_valid_next;
  logic [15:0] w_pc_plus2;
  logic        w_is_hlt;

  // 16-bit add wraps 16'hFFFE to 16'h0000 on its own.
  assign w_pc_plus2 = r_pc + 16'd2;
  assign w_is_hlt   = (imem_data[15:12] == 4'hF);

  always_comb begin
    w_state_next    = r_state;
    w_pc_next       = r_pc;
    w_instr_next    = r_instr;
    w_ifid_pc2_next = r_ifid_pc2;
    w_valid_next    = r_valid;

    if (flush) begin
      w_pc_next       = {branch_target[15:1], 1'b0};
      w_instr_next    = 16'h0000;
      w_ifid_pc2_next = 16'h0000;
      w_valid_next    = 1'b0;
      w_state_next    = S_RUN;
    end else if (!stall) begin
      case (r_state)
        S_RUN: begin
          w_instr_next    = imem_data;
          w_ifid_pc2_next = w_pc_plus2;
          w_valid_next    = 1'b1;
          // HLT still goes downstream, but the PC parks on it.
          if (w_is_hlt) begin
            w_state_next = S_HALTED;
          end else begin
            w_pc_next = w_pc_plus2;
          end
        end
        S_HALTED: begin
          w_instr_next    = 16'h0000;
          w_ifid_pc2_next = 16'h0000;
          w_valid_next    = 1'b0;
        end
        default: begin
          w_state_next = S_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_RUN;
      r_pc       <= 16'h0000;
      r_instr    <= 16'h0000;
      r_ifid_pc2 <= 16'h0000;
      r_valid    <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_pc       <= w_pc_next;
      r_instr    <= w_instr_next;
      r_ifid_pc2 <= w_ifid_pc2_next;
      r_valid    <= w_valid_next;
    end
  end

  assign imem_addr   = r_pc;
  assign instr_out   = r_instr;
  assign pc_next_out = r_ifid_pc2;
  assign valid_out   = r_valid;
  assign halted      = (r_state == S_HALTED);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a table of per-cycle vectors plus
// hand-written sequences for asynchronous reset behaviour.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic [15:0] branch_target;
  logic [15:0] imem_data;
  logic [15:0] imem_addr;
  logic [15:0] instr_out;
  logic [15:0] pc_next_out;
  logic        valid_out;
  logic        halted;

  logic [15:0] mem [0:255];

  int checks;
  int errors;

  typedef struct {
    logic        stall;
    logic        flush;
    logic [15:0] bt;
    logic [15:0] pc;
    logic [15:0] instr;
    logic [15:0] pcn;
    logic        valid;
    logic        halted;
  } vec_t;

  vec_t vecs [17];

  fetch_stage dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .flush         (flush),
    .branch_target (branch_target),
    .imem_data     (imem_data),
    .imem_addr     (imem_addr),
    .instr_out     (instr_out),
    .pc_next_out   (pc_next_out),
    .valid_out     (valid_out),
    .halted        (halted)
  );

  // Memory covers addresses 0x000-0x1FE; higher addresses alias (0xFFFE -> entry 255).
  assign imem_data = mem[imem_addr[8:1]];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [15:0] pc, input logic [15:0] ins,
                         input logic [15:0] pcn, input logic v, input logic h);
    chk({tag, ".imem_addr"},   imem_addr,   pc);
    chk({tag, ".instr_out"},   instr_out,   ins);
    chk({tag, ".pc_next_out"}, pc_next_out, pcn);
    chk({tag, ".valid_out"},   {15'd0, valid_out}, {15'd0, v});
    chk({tag, ".halted"},      {15'd0, halted},    {15'd0, h});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0100 + 16'(i);
    mem[0]   = 16'h1234;
    mem[1]   = 16'h2345;
    mem[8]   = 16'hF000;

    //            stall flush bt        pc        instr     pcn       v     h
    vecs[0]  = '{1'b0, 1'b0, 16'h0000, 16'h0002, 16'h1234, 16'h0002, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 16'h0000, 16'h0004, 16'h2345, 16'h0004, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 16'h0000, 16'h0004, 16'h2345, 16'h0004, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 16'h0000, 16'h0004, 16'h2345, 16'h0004, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 16'h0000, 16'h0006, 16'h0102, 16'h0006, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 16'h0031, 16'h0030, 16'h0000, 16'h0000, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 16'h0000, 16'h0032, 16'h0118, 16'h0032, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 16'h0010, 16'h0010, 16'h0000, 16'h0000, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 16'h0000, 16'h0010, 16'hF000, 16'h0012, 1'b1, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 16'h0000, 16'h0010, 16'h0000, 16'h0000, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 16'h0000, 16'h0010, 16'h0000, 16'h0000, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 16'h0000, 16'h0010, 16'h0000, 16'h0000, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 1'b1, 16'h0040, 16'h0040, 16'h0000, 16'h0000, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 16'h0000, 16'h0042, 16'h0120, 16'h0042, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 16'hFFFF, 16'hFFFE, 16'h0000, 16'h0000, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 16'h01FF, 16'h0000, 1'b1, 1'b0};
    vecs[16] = '{1'b0, 1'b0, 16'h0000, 16'h0002, 16'h1234, 16'h0002, 1'b1, 1'b0};

    rst = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    branch_target = 16'h0000;
    #2;
    chk_all("reset", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      stall         = vecs[i].stall;
      flush         = vecs[i].flush;
      branch_target = vecs[i].bt;
      @(posedge clk);
      #1;
      chk_all($sformatf("vec%0d", i), vecs[i].pc, vecs[i].instr, vecs[i].pcn,
              vecs[i].valid, vecs[i].halted);
      $display("vec%0d stall=%b flush=%b bt=%h -> pc=%h instr=%h pcn=%h v=%b h=%b",
               i, stall, flush, branch_target, imem_addr, instr_out, pc_next_out,
               valid_out, halted);
    end

    // Reach halted with valid HLT in IF/ID, then pulse reset between edges.
    stall = 1'b0;
    flush = 1'b1;
    branch_target = 16'h0010;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(posedge clk);
    #1;
    chk_all("pre_rst", 16'h0010, 16'hF000, 16'h0012, 1'b1, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk_all("async_rst", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    $display("async reset pulse -> pc=%h instr=%h v=%b h=%b", imem_addr, instr_out, valid_out, halted);

    // Reset held across edges with stall and flush active must dominate.
    stall = 1'b1;
    flush = 1'b1;
    branch_target = 16'h0080;
    @(posedge clk);
    #1;
    chk_all("rst_over_flush", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    @(posedge clk);
    #1;
    chk_all("first_fetch", 16'h0002, 16'h1234, 16'h0002, 1'b1, 1'b0);
    $display("first fetch after reset -> pc=%h instr=%h pcn=%h", imem_addr, instr_out, pc_next_out);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have exactly one clock, `clk`, and an asynchronous, active-high reset, `rst`.
REQ-002 Port list, in order (name, direction, width, meaning), SHALL be:
- `clk`, in, 1: rising-edge clock.
- `rst`, in, 1: asynchronous active-high reset.
- `stall`, in, 1: hold PC and IF/ID contents (decode hazard).
- `flush`, in, 1: redirect fetch to `branch_target` and squash IF/ID (taken branch).
- `branch_target`, in, 16: redirect address.
- `imem_data`, in, 16: instruction word at `imem_addr`, combinational read.
- `imem_addr`, out, 16: current PC.
- `instr_out`, out, 16: IF/ID instruction register; feeds decode.
- `pc_next_out`, out, 16: IF/ID PC+2 register; used for branch/PCS.
- `valid_out`, out, 1: IF/ID holds a real instruction.
- `halted`, out, 1: fetch has stopped on HLT.

Function
REQ-003 `imem_addr` SHALL equal the PC register combinationally; the PC SHALL always be even.
REQ-004 State machine SHALL have two states, RUN and HALTED; `halted` SHALL be 1 exactly in HALTED.
REQ-005 Update priority per cycle SHALL be flush > stall > halt/normal.
REQ-006 On flush (any state, with or without stall):
- PC <= {branch_target[15:1], 1'b0}.
- IF/ID <= bubble: `instr_out` = 16'h0000, `pc_next_out` = 16'h0000, `valid_out` = 0.
- State <= RUN.
REQ-007 Stall without flush SHALL hold PC, IF/ID and state unchanged, in either state.
REQ-008 RUN, no stall, no flush, `imem_data[15:12]` != 4'hF:
- IF/ID <= {`imem_data`, PC+2, valid = 1}.
- PC <= PC+2.
REQ-009 RUN, no stall, no flush, `imem_data[15:12]` == 4'hF (HLT):
- IF/ID <= {`imem_data`, PC+2, valid = 1}, so HLT propagates downstream.
- PC holds.
- State <= HALTED.
REQ-010 HALTED, no stall, no flush: PC holds and IF/ID <= bubble every cycle.
REQ-011 PC+2 SHALL be 16-bit modulo: 16'hFFFE wraps to 16'h0000, with no error indication.
REQ-012 Fetch-to-decode latency SHALL be one cycle: the word at address A appears on `instr_out` the cycle after PC = A with no stall.
REQ-013 The block SHALL NOT decode any opcode other than checking 4'hF in `imem_data[15:12]`.

Reset
REQ-014 While `rst` = 1, asynchronously and independent of `clk`:
- PC = 16'h0000 and `imem_addr` = 16'h0000.
- `instr_out` = 16'h0000, `pc_next_out` = 16'h0000, `valid_out` = 0.
- State = RUN, `halted` = 0.
REQ-015 Reset asserted mid-stall, mid-halt or mid-flush SHALL override everything.
REQ-016 First fetch after reset SHALL be from 16'h0000 on the first rising edge after `rst` deasserts.
REQ-017 Reset SHALL be the only way to leave HALTED other than flush.

Verification
REQ-018 Sequential fetch: imem returns 16'h1234 @0, 16'h2345 @2; no stall/flush -> cycle 1: `instr_out` = 16'h1234, `pc_next_out` = 16'h0002, `valid_out` = 1; cycle 2: 16'h2345 / 16'h0004.
REQ-019 Stall for 2 cycles at PC = 16'h0004 -> `imem_addr` stays 16'h0004 and IF/ID unchanged for both cycles; fetch resumes on the cycle stall drops.
REQ-020 Flush with `branch_target` = 16'h0031 while `stall` = 1 -> next cycle: PC = 16'h0030, `valid_out` = 0, `instr_out` = 16'h0000.
REQ-021 HLT 16'hF000 at 16'h0010 -> next cycle: `instr_out` = 16'hF000, `valid_out` = 1, `halted` = 1, PC = 16'h0010; following cycles: `valid_out` = 0 and PC unchanged.
REQ-022 Halted, then flush to 16'h0040 -> `halted` = 0 and PC = 16'h0040 next cycle; also PC = 16'hFFFE with no stall -> PC = 16'h0000 and `pc_next_out` = 16'h0000 next cycle.
REQ-023 `rst` pulsed between clock edges while `valid_out` = 1 and `halted` = 1 -> all outputs at reset values immediately, before the next edge.
